router_port_rx: RTL
===================

# router_port_rx

Receive-side endpoint for one router output port. Samples the serial `frameo_n`/`valido_n`/`dout` stream, reassembles LSB-first bytes, and buffers them in a small FIFO. Bytes are presented on a byte-wide valid/ready stream with a packet-end marker. One instance sits behind each of the 16 router output ports and is the synthesizable counterpart of the stimulus side that drives `din`/`frame_n`/`valid_n`.

## Interface
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the packet counter.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `frameo_n` in 1: router frame, active-low; rises during the last valid bit of a packet.
- `valido_n` in 1: router bit-valid, active-low.
- `dout` in 1: router serial data; meaningful only when `valido_n`=0.
- `busy_n` out 1: low while a packet is in progress (FSM in ACTIVE).
- `m_data` out 8: head-of-FIFO byte.
- `m_last` out 1: head byte is the final byte of its packet.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head byte when `m_valid`&`m_ready`.
- `err_partial` out 1: sticky; a packet ended with 1–7 leftover bits.
- `err_overflow` out 1: sticky; a completed byte found the FIFO full.
- `pkt_count` out CNT_W: packets ended since reset; wraps modulo 2^CNT_W.

## Operation
- FSM states IDLE and ACTIVE. Reset value is IDLE.
  - IDLE → ACTIVE when `frameo_n`=0 is sampled.
  - ACTIVE → IDLE on the end event.
- End event: `frameo_n`=1 sampled while in ACTIVE, or `frameo_n`=1 & `valido_n`=0 sampled in IDLE (a one-bit packet).
- Bit capture: on each edge with `valido_n`=0, `dout` is shifted into bit position `bit_cnt` (3-bit counter, LSB first). The counter then increments and wraps 7→0.
  - Bits sampled with `valido_n`=1 are ignored; these are the padding cycles.
- Byte completion: capture with `bit_cnt`=7. The assembled byte, including the current bit, is written to the FIFO.
  - `last` = end event in the same cycle.
  - FIFO full at the write: the byte is dropped and `err_overflow` is set.
  - A pop in the same cycle frees space first, so a full FIFO with a pop accepts the write.
- End event with `bit_cnt`≠0 after the capture: the partial bits are discarded, `err_partial` is set, and `bit_cnt` clears.
  - No `last` byte is written for that packet. The consumer detects the loss via `err_partial`.
- End with no valid bits at all (frame low then high, no `valido_n`): `pkt_count` increments, nothing is written, no error.
- `pkt_count` increments once per end event.
- `busy_n` = 0 in ACTIVE, 1 in IDLE.
- Error flags clear only on `reset`.
- Reset mid-packet: FSM, `bit_cnt`, shift register, FIFO pointers, counters and flags all clear immediately. Remaining bits of that packet are treated as a new frame only after `frameo_n` is seen low again from IDLE.

## Timing
- Reset values:
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `busy_n`=1.
  - `err_partial`=0, `err_overflow`=0.
  - `pkt_count`=0.
- Latency: the byte whose 8th bit is sampled at edge N shows `m_valid`=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- `busy_n` falls one cycle after `frameo_n`=0 is sampled. It rises one cycle after the end event.
- Error flags and `pkt_count` update on the edge that samples the causing event.
- The serial side never stalls. Throughput is one bit per clock; `m_ready` may be held low indefinitely, at the cost of overflow.
- `m_data`/`m_last` are stable while `m_valid`=1 & `m_ready`=0.

## Structure
- Package `router_rx_pkg`: `BYTE_W`=8, `BIT_CNT_W`=3, enum `rx_state_e` {IDLE, ACTIVE}, packed struct `rx_entry_t` {`last`, `data[7:0]`}.
- Sub-module `rx_byte_fifo`: synchronous FIFO of `rx_entry_t`, depth `FIFO_DEPTH`, with count-based full/empty and same-cycle push/pop.
- The FSM, bit counter, shift register and flags stay in the top.

## Test plan
- Packet bytes 0xA5, 0x3C, with `m_ready`=1 → `m_data` shows 0xA5 (`last`=0) then 0x3C (`last`=1); `pkt_count`=1; no errors.
- Packet with 5 padding cycles (`valido_n`=1, `frameo_n`=0) between address-style bits and data → padding is ignored; byte values unaffected.
- Packet of 12 bits → one byte written with `last`=0; `err_partial`=1; `pkt_count`=1; `busy_n` returns to 1.
- `m_ready`=0, `FIFO_DEPTH`=8, 10-byte packet → 8 bytes buffered; `err_overflow`=1; draining yields the first 8 bytes in order, none marked last.
- `reset` asserted at bit 4 of byte 2 → all outputs at reset values the next cycle; a subsequent clean 1-byte packet 0x81 is received with `last`=1 and `pkt_count`=1.
- Back-to-back packets (`frameo_n` high for exactly one cycle between them) → both delivered; `pkt_count`=2; `m_last` marks each final byte.

Source files
------------

// File: rtl/router_rx_pkg.sv
// Shared types and widths for the router output-port receive path.
package router_rx_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO with count-based full/empty; a same-cycle pop frees room for a push.
module rx_byte_fifo
  import router_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  rx_entry_t wr_entry,
  input  logic      pop,
  output rx_entry_t rd_entry,
  output logic      empty,
  output logic      full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rx_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Masked so the head reads as zero whenever nothing is buffered.
  assign rd_entry = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// Router output-port receiver: serial LSB-first bit capture into a byte FIFO with
// packet-end marking, sticky error flags and a packet counter.
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frameo_n,
  input  logic             valido_n,
  input  logic             dout,
  output logic             busy_n,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             err_partial,
  output logic             err_overflow,
  output logic [CNT_W-1:0] pkt_count
);

  rx_state_e            state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_inc;
  logic [BYTE_W-2:0]    shift_q;
  logic                 capture;
  logic                 end_evt;
  logic                 byte_done;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 overflow;
  rx_entry_t            wr_entry;
  rx_entry_t            rd_entry;

  assign capture     = ~valido_n;
  // In IDLE only a valid bit with frame already high is a (one-bit) packet end.
  assign end_evt     = frameo_n & ((state_q == ACTIVE) | ~valido_n);
  assign byte_done   = capture & (bit_cnt_q == BIT_CNT_W'(7));
  assign bit_cnt_inc = bit_cnt_q + BIT_CNT_W'(capture);
  assign pop         = m_valid & m_ready;
  assign overflow    = byte_done & fifo_full & ~pop;
  assign wr_entry    = '{last: end_evt, data: {dout, shift_q}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_n       <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      pkt_count    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!frameo_n) begin
            state_q <= ACTIVE;
            busy_n  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (frameo_n) begin
            state_q <= IDLE;
            busy_n  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_n  <= 1'b1;
        end
      endcase

      // Bit 7 goes straight into the FIFO entry, so only bits 0..6 are held.
      if (capture && !byte_done) begin
        shift_q[bit_cnt_q] <= dout;
      end

      bit_cnt_q <= end_evt ? '0 : bit_cnt_inc;

      if (end_evt && (bit_cnt_inc != '0)) begin
        err_partial <= 1'b1;
      end
      if (overflow) begin
        err_overflow <= 1'b1;
      end
      if (end_evt) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (byte_done),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (rd_entry),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = rd_entry.data;
  assign m_last  = rd_entry.last;

endmodule
